module_dmem_responder: RTL and testbench
========================================

MODULE_DMEM_RESPONDER -- requirements
Module: module_dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, giving the number of 32-bit RAM words (power of two).
REQ-002 The block SHALL have parameter MMIO_NIBBLE, default 4'h1, giving the value of address bits [31:28] that selects the MMIO region.
REQ-003 clk_i  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 MemWriteM_i  in  1  store strobe from the core M stage; one store per cycle when high.
REQ-006 ALUResultM_i  in  32  byte address of the load or store.
REQ-007 WriteDataM_i  in  32  store data.
REQ-008 ReadDataM_o  out  32  load data, combinational from the current address and state.
REQ-009 gpio_o  out  8  GPIO output register.
REQ-010 timer_irq_o  out  1  registered timer-match flag.

Function
REQ-011 Decode SHALL be as follows:
- MMIO when addr[31:28]==MMIO_NIBBLE.
- RAM when addr < DEPTH*4.
- Otherwise unmapped.
- addr[1:0] SHALL be ignored everywhere.
REQ-012 RAM index SHALL be addr[$clog2(DEPTH)+1:2]; a RAM store SHALL write the full word at the clock edge while MemWriteM_i=1.
REQ-013 A RAM load SHALL return the stored word in the same cycle (zero-wait); a same-cycle store to the same address SHALL return the old data, and the new data SHALL be visible from the next cycle.
REQ-014 Unmapped loads SHALL return 0; unmapped stores SHALL be discarded and SHALL set STATUS.bad.
REQ-015 The MMIO map SHALL be (offset = addr[4:2]):
- 0 MTIME (RW)
- 1 MTIMECMP (RW)
- 2 STATUS (bit0 match, bit1 bad; W1C)
- 3 GPIO (RW; bits[7:0] only)
- 4 STORE_CNT (RO)
- Offsets 5-7 and addr[27:5]!=0 SHALL read 0, writes ignored, no flag set.
REQ-016 MTIME SHALL increment by 1 every cycle and wrap from 0xFFFF_FFFF to 0; a store to MTIME SHALL load WriteDataM_i with no increment that cycle.
REQ-017 STATUS.match SHALL be set on the edge following any cycle in which MTIME==MTIMECMP (pre-edge values); a same-cycle W1C and set SHALL leave the bit set.
REQ-018 STATUS.bad set and W1C in the same cycle SHALL leave the bit set.
REQ-019 timer_irq_o SHALL equal STATUS.match.
REQ-020 gpio_o SHALL equal GPIO[7:0]; GPIO reads SHALL return {24'b0, GPIO}.
REQ-021 STORE_CNT SHALL increment on each edge with MemWriteM_i=1 and a RAM or defined writable MMIO target (offsets 0-3), saturating at 0xFFFF_FFFF.
REQ-022 Stores to STORE_CNT SHALL be ignored and SHALL NOT count.
REQ-023 When MemWriteM_i=0, no state other than MTIME, STATUS.match, and the free-running compare SHALL change.

Reset
REQ-024 Asserting rst_i SHALL immediately set:
- MTIME=0
- MTIMECMP=0xFFFF_FFFF
- STATUS=0
- GPIO=0
- STORE_CNT=0
- gpio_o=0, timer_irq_o=0
REQ-025 RAM contents SHALL NOT be reset.
REQ-026 Reset asserted mid-store SHALL discard the store.
REQ-027 After deassertion, MTIME SHALL read 0 in the first cycle and 1 in the second.

Verification
REQ-028 Store 0xDEAD_BEEF to 0x0000_0010, then load 0x0000_0013 next cycle -> 0xDEAD_BEEF; a load of 0x10 in the store cycle returns the prior content.
REQ-029 Store 0x0000_0005 to MTIMECMP, with MTIME reset at 0 -> timer_irq_o rises on the edge after MTIME reads 5; W1C 0x1 to STATUS clears it; the same-cycle match+clear case keeps it set.
REQ-030 Store 0xFFFF_FFFE to MTIME -> reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0 on successive cycles.
REQ-031 Store 0x1234_56A5 to GPIO -> gpio_o=0xA5 and a load returns 0x0000_00A5; store to 0x0000_0400 (DEPTH=256) -> STATUS=0x2, load returns 0, RAM unchanged.
REQ-032 Three stores: RAM, STORE_CNT offset, unmapped -> STORE_CNT reads 1.
REQ-033 Assert rst_i asynchronously mid-cycle with GPIO=0xFF -> gpio_o=0 before the next edge; RAM word written earlier is still readable after reset.

Source files
------------

// File: rtl/module_dmem_responder.sv
// ============================================================================
// Module      : module_dmem_responder
// Description : Data-memory responder for the core M stage. Zero-wait word
//               RAM plus a small MMIO block (MTIME/MTIMECMP timer, W1C
//               STATUS, GPIO output register, saturating store counter).
//               Loads are combinational; stores commit on the rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module module_dmem_responder #(
    parameter int         DEPTH       = 256,
    parameter logic [3:0] MMIO_NIBBLE = 4'h1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemWriteM_i,
    input  logic [31:0] ALUResultM_i,
    input  logic [31:0] WriteDataM_i,
    output logic [31:0] ReadDataM_o,
    output logic [7:0]  gpio_o,
    output logic        timer_irq_o
);

    // RAM index width and the first byte address past the RAM window.
    localparam int          c_IDX_W     = $clog2(DEPTH);
    localparam logic [31:0] c_RAM_BYTES = 32'(DEPTH * 4);

    // MMIO register offsets (word offset inside the MMIO window).
    localparam logic [2:0] c_OFF_MTIME    = 3'd0;
    localparam logic [2:0] c_OFF_MTIMECMP = 3'd1;
    localparam logic [2:0] c_OFF_STATUS   = 3'd2;
    localparam logic [2:0] c_OFF_GPIO     = 3'd3;
    localparam logic [2:0] c_OFF_STORECNT = 3'd4;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] r_ram [DEPTH];
    logic [31:0] r_mtime;
    logic [31:0] r_mtimeCmp;
    logic        r_match;
    logic        r_bad;
    logic [7:0]  r_gpio;
    logic [31:0] r_storeCnt;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic               w_isMmio;
    logic               w_isRam;
    logic               w_mmioHit;
    logic [2:0]         w_off;
    logic [c_IDX_W-1:0] w_ramIdx;

    // MMIO takes priority so a zero MMIO_NIBBLE cannot alias into RAM.
    assign w_isMmio  = (ALUResultM_i[31:28] == MMIO_NIBBLE);
    assign w_isRam   = !w_isMmio && (ALUResultM_i < c_RAM_BYTES);
    // Only the first 32 bytes of the MMIO window hold registers; the rest
    // of the window reads as zero and silently drops writes.
    assign w_mmioHit = w_isMmio && (ALUResultM_i[27:5] == 23'd0);
    assign w_off     = ALUResultM_i[4:2];
    assign w_ramIdx  = ALUResultM_i[c_IDX_W+1:2];

    // ------------------------------------------------------------------
    // Write strobes
    // ------------------------------------------------------------------
    logic w_wrRam;
    logic w_wrMtime;
    logic w_wrCmp;
    logic w_wrStatus;
    logic w_wrGpio;
    logic w_badStore;
    logic w_countable;
    logic w_timeEq;

    assign w_wrRam     = MemWriteM_i && w_isRam;
    assign w_wrMtime   = MemWriteM_i && w_mmioHit && (w_off == c_OFF_MTIME);
    assign w_wrCmp     = MemWriteM_i && w_mmioHit && (w_off == c_OFF_MTIMECMP);
    assign w_wrStatus  = MemWriteM_i && w_mmioHit && (w_off == c_OFF_STATUS);
    assign w_wrGpio    = MemWriteM_i && w_mmioHit && (w_off == c_OFF_GPIO);
    assign w_badStore  = MemWriteM_i && !w_isMmio && !w_isRam;
    // STORE_CNT itself and the reserved offsets are not counted.
    assign w_countable = w_wrRam || w_wrMtime || w_wrCmp || w_wrStatus || w_wrGpio;
    assign w_timeEq    = (r_mtime == r_mtimeCmp);

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // RAM word write; contents survive reset, but a store coinciding with
    // reset is dropped.
    always_ff @(posedge clk_i) begin
        if (w_wrRam && !rst_i) begin
            r_ram[w_ramIdx] <= WriteDataM_i;
        end
    end

    // Free-running timer; a store overrides the increment for that cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mtime <= 32'd0;
        end else if (w_wrMtime) begin
            r_mtime <= WriteDataM_i;
        end else begin
            r_mtime <= r_mtime + 32'd1;
        end
    end

    // Timer compare value, parked at all-ones out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mtimeCmp <= 32'hFFFF_FFFF;
        end else if (w_wrCmp) begin
            r_mtimeCmp <= WriteDataM_i;
        end
    end

    // STATUS flags: a set event in the same cycle as W1C wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_match <= 1'b0;
            r_bad   <= 1'b0;
        end else begin
            r_match <= w_timeEq   || (r_match && !(w_wrStatus && WriteDataM_i[0]));
            r_bad   <= w_badStore || (r_bad   && !(w_wrStatus && WriteDataM_i[1]));
        end
    end

    // GPIO output register keeps only the low byte of the store data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_gpio <= 8'd0;
        end else if (w_wrGpio) begin
            r_gpio <= WriteDataM_i[7:0];
        end
    end

    // Saturating count of stores that landed on a real writable target.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_storeCnt <= 32'd0;
        end else if (w_countable && (r_storeCnt != 32'hFFFF_FFFF)) begin
            r_storeCnt <= r_storeCnt + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Load data and outputs
    // ------------------------------------------------------------------

    // Zero-wait load mux; unmapped and reserved locations read as zero.
    always_comb begin
        ReadDataM_o = 32'd0;
        if (w_isRam) begin
            ReadDataM_o = r_ram[w_ramIdx];
        end else if (w_mmioHit) begin
            case (w_off)
                c_OFF_MTIME:    ReadDataM_o = r_mtime;
                c_OFF_MTIMECMP: ReadDataM_o = r_mtimeCmp;
                c_OFF_STATUS:   ReadDataM_o = {30'd0, r_bad, r_match};
                c_OFF_GPIO:     ReadDataM_o = {24'd0, r_gpio};
                c_OFF_STORECNT: ReadDataM_o = r_storeCnt;
                default:        ReadDataM_o = 32'd0;
            endcase
        end
    end

    assign gpio_o      = r_gpio;
    assign timer_irq_o = r_match;

endmodule

`default_nettype wire

// File: tb/tb_module_dmem_responder.sv
// ============================================================================
// Module      : tb_module_dmem_responder
// Description : Directed self-checking bench for module_dmem_responder
//               (DEPTH=256, MMIO_NIBBLE=1). Inputs change on the falling
//               edge; outputs are sampled 1 ns later.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_module_dmem_responder;

    localparam logic [31:0] c_A_MTIME    = 32'h1000_0000;
    localparam logic [31:0] c_A_CMP      = 32'h1000_0004;
    localparam logic [31:0] c_A_STATUS   = 32'h1000_0008;
    localparam logic [31:0] c_A_GPIO     = 32'h1000_000C;
    localparam logic [31:0] c_A_STORECNT = 32'h1000_0010;

    logic        clk_i;
    logic        rst_i;
    logic        MemWriteM_i;
    logic [31:0] ALUResultM_i;
    logic [31:0] WriteDataM_i;
    logic [31:0] ReadDataM_o;
    logic [7:0]  gpio_o;
    logic        timer_irq_o;

    int checkCount = 0;
    int errCount   = 0;

    module_dmem_responder #(
        .DEPTH       (256),
        .MMIO_NIBBLE (4'h1)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .MemWriteM_i  (MemWriteM_i),
        .ALUResultM_i (ALUResultM_i),
        .WriteDataM_i (WriteDataM_i),
        .ReadDataM_o  (ReadDataM_o),
        .gpio_o       (gpio_o),
        .timer_irq_o  (timer_irq_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Issue one store at the current falling edge; returns at the next one.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        MemWriteM_i  = 1'b1;
        ALUResultM_i = a;
        WriteDataM_i = d;
        @(negedge clk_i);
        MemWriteM_i  = 1'b0;
    endtask

    task automatic test_reset;
        rst_i = 1'b1; MemWriteM_i = 1'b0; ALUResultM_i = '0; WriteDataM_i = '0;
        @(negedge clk_i); @(negedge clk_i);
        #1;
        checkCount++; if (gpio_o !== 8'h00) begin errCount++; $display("FAIL rst_gpio got=%h exp=00", gpio_o); end
        checkCount++; if (timer_irq_o !== 1'b0) begin errCount++; $display("FAIL rst_irq got=%b exp=0", timer_irq_o); end
        ALUResultM_i = c_A_CMP; #1;
        checkCount++; if (ReadDataM_o !== 32'hFFFF_FFFF) begin errCount++; $display("FAIL rst_cmp got=%h exp=ffffffff", ReadDataM_o); end
        ALUResultM_i = c_A_STATUS; #1;
        checkCount++; if (ReadDataM_o !== 32'h0) begin errCount++; $display("FAIL rst_status got=%h exp=0", ReadDataM_o); end
        ALUResultM_i = c_A_STORECNT; #1;
        checkCount++; if (ReadDataM_o !== 32'h0) begin errCount++; $display("FAIL rst_storecnt got=%h exp=0", ReadDataM_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
        ALUResultM_i = c_A_MTIME; #1;
        checkCount++; if (ReadDataM_o !== 32'd0) begin errCount++; $display("FAIL rst_mtime_first got=%h exp=0", ReadDataM_o); end
        @(negedge clk_i); #1;
        checkCount++; if (ReadDataM_o !== 32'd1) begin errCount++; $display("FAIL rst_mtime_second got=%h exp=1", ReadDataM_o); end
    endtask

    task automatic test_ram;
        @(negedge clk_i);
        do_store(32'h0000_0010, 32'h1111_1111);
        do_store(32'h0000_0000, 32'h0BAD_C0DE);
        do_store(32'h0000_03FC, 32'h7E57_CAFE);
        MemWriteM_i = 1'b1; ALUResultM_i = 32'h0000_0010; WriteDataM_i = 32'hDEAD_BEEF;
        #1;
        checkCount++; if (ReadDataM_o !== 32'h1111_1111) begin errCount++; $display("FAIL ram_same_cycle_old got=%h exp=11111111", ReadDataM_o); end
        @(negedge clk_i);
        MemWriteM_i = 1'b0; ALUResultM_i = 32'h0000_0013; #1;
        checkCount++; if (ReadDataM_o !== 32'hDEAD_BEEF) begin errCount++; $display("FAIL ram_next_cycle got=%h exp=deadbeef", ReadDataM_o); end
        ALUResultM_i = 32'h0000_03FF; #1;
        checkCount++; if (ReadDataM_o !== 32'h7E57_CAFE) begin errCount++; $display("FAIL ram_last_word got=%h exp=7e57cafe", ReadDataM_o); end
        ALUResultM_i = 32'h0000_0002; #1;
        checkCount++; if (ReadDataM_o !== 32'h0BAD_C0DE) begin errCount++; $display("FAIL ram_word0 got=%h exp=0badc0de", ReadDataM_o); end
    endtask

    task automatic test_timer;
        @(negedge clk_i);
        do_store(c_A_MTIME, 32'd0);
        do_store(c_A_CMP, 32'd5);
        ALUResultM_i = c_A_MTIME; #1;
        checkCount++; if (ReadDataM_o !== 32'd1) begin errCount++; $display("FAIL timer_mtime got=%h exp=1", ReadDataM_o); end
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk_i); #1;
            checkCount++; if (ReadDataM_o !== 32'(k)) begin errCount++; $display("FAIL timer_count got=%h exp=%h", ReadDataM_o, 32'(k)); end
            checkCount++; if (timer_irq_o !== 1'b0) begin errCount++; $display("FAIL timer_irq_early got=%b exp=0", timer_irq_o); end
        end
        @(negedge clk_i); #1;
        checkCount++; if (timer_irq_o !== 1'b1) begin errCount++; $display("FAIL timer_irq_rise got=%b exp=1", timer_irq_o); end
        ALUResultM_i = c_A_STATUS; #1;
        checkCount++; if (ReadDataM_o !== 32'h1) begin errCount++; $display("FAIL timer_status got=%h exp=1", ReadDataM_o); end
        do_store(c_A_STATUS, 32'h1);
        #1;
        checkCount++; if (timer_irq_o !== 1'b0) begin errCount++; $display("FAIL timer_w1c got=%b exp=0", timer_irq_o); end
        do_store(c_A_CMP, 32'd9);
        @(negedge clk_i);
        ALUResultM_i = c_A_MTIME; #1;
        checkCount++; if (ReadDataM_o !== 32'd9) begin errCount++; $display("FAIL timer_mtime9 got=%h exp=9", ReadDataM_o); end
        do_store(c_A_STATUS, 32'h1);
        #1;
        checkCount++; if (timer_irq_o !== 1'b1) begin errCount++; $display("FAIL timer_match_and_clear got=%b exp=1", timer_irq_o); end
        do_store(c_A_STATUS, 32'h1);
        #1;
        checkCount++; if (timer_irq_o !== 1'b0) begin errCount++; $display("FAIL timer_clear2 got=%b exp=0", timer_irq_o); end
    endtask

    task automatic test_mtime_wrap;
        @(negedge clk_i);
        do_store(c_A_MTIME, 32'hFFFF_FFFE);
        ALUResultM_i = c_A_MTIME; #1;
        checkCount++; if (ReadDataM_o !== 32'hFFFF_FFFE) begin errCount++; $display("FAIL wrap_fffe got=%h exp=fffffffe", ReadDataM_o); end
        @(negedge clk_i); #1;
        checkCount++; if (ReadDataM_o !== 32'hFFFF_FFFF) begin errCount++; $display("FAIL wrap_ffff got=%h exp=ffffffff", ReadDataM_o); end
        @(negedge clk_i); #1;
        checkCount++; if (ReadDataM_o !== 32'h0) begin errCount++; $display("FAIL wrap_zero got=%h exp=0", ReadDataM_o); end
    endtask

    task automatic test_gpio_unmapped;
        @(negedge clk_i);
        do_store(c_A_CMP, 32'h8000_0000);
        do_store(c_A_STATUS, 32'h3);
        do_store(c_A_GPIO, 32'h1234_56A5);
        #1;
        checkCount++; if (gpio_o !== 8'hA5) begin errCount++; $display("FAIL gpio_out got=%h exp=a5", gpio_o); end
        ALUResultM_i = c_A_GPIO; #1;
        checkCount++; if (ReadDataM_o !== 32'h0000_00A5) begin errCount++; $display("FAIL gpio_read got=%h exp=000000a5", ReadDataM_o); end
        ALUResultM_i = 32'h1000_002C; #1;
        checkCount++; if (ReadDataM_o !== 32'h0) begin errCount++; $display("FAIL mmio_hole_read got=%h exp=0", ReadDataM_o); end
        @(negedge clk_i);
        do_store(32'h1000_0014, 32'hFFFF_FFFF);
        ALUResultM_i = 32'h1000_0014; #1;
        checkCount++; if (ReadDataM_o !== 32'h0) begin errCount++; $display("FAIL mmio_off5_read got=%h exp=0", ReadDataM_o); end
        ALUResultM_i = c_A_STATUS; #1;
        checkCount++; if (ReadDataM_o !== 32'h0) begin errCount++; $display("FAIL mmio_off5_noflag got=%h exp=0", ReadDataM_o); end
        @(negedge clk_i);
        do_store(32'h0000_0400, 32'hCAFE_F00D);
        ALUResultM_i = c_A_STATUS; #1;
        checkCount++; if (ReadDataM_o !== 32'h2) begin errCount++; $display("FAIL unmapped_bad got=%h exp=2", ReadDataM_o); end
        ALUResultM_i = 32'h0000_0400; #1;
        checkCount++; if (ReadDataM_o !== 32'h0) begin errCount++; $display("FAIL unmapped_read got=%h exp=0", ReadDataM_o); end
        ALUResultM_i = 32'h0000_0000; #1;
        checkCount++; if (ReadDataM_o !== 32'h0BAD_C0DE) begin errCount++; $display("FAIL unmapped_ram0 got=%h exp=0badc0de", ReadDataM_o); end
        ALUResultM_i = 32'h0000_03FC; #1;
        checkCount++; if (ReadDataM_o !== 32'h7E57_CAFE) begin errCount++; $display("FAIL unmapped_ramlast got=%h exp=7e57cafe", ReadDataM_o); end
        @(negedge clk_i);
        do_store(32'h1000_0028, 32'h2);
        ALUResultM_i = c_A_STATUS; #1;
        checkCount++; if (ReadDataM_o !== 32'h2) begin errCount++; $display("FAIL hole_no_w1c got=%h exp=2", ReadDataM_o); end
        @(negedge clk_i);
        do_store(c_A_STATUS, 32'h2);
        ALUResultM_i = c_A_STATUS; #1;
        checkCount++; if (ReadDataM_o !== 32'h0) begin errCount++; $display("FAIL bad_w1c got=%h exp=0", ReadDataM_o); end
    endtask

    task automatic test_store_cnt;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        do_store(32'h0000_0020, 32'h0000_AAAA);
        do_store(c_A_STORECNT, 32'h77);
        do_store(32'h0000_0800, 32'h1);
        ALUResultM_i = c_A_STORECNT; #1;
        checkCount++; if (ReadDataM_o !== 32'd1) begin errCount++; $display("FAIL cnt_three got=%h exp=1", ReadDataM_o); end
        ALUResultM_i = c_A_STATUS; #1;
        checkCount++; if (ReadDataM_o !== 32'h2) begin errCount++; $display("FAIL cnt_bad got=%h exp=2", ReadDataM_o); end
        @(negedge clk_i);
        do_store(c_A_GPIO, 32'h3C);
        do_store(32'h1000_0014, 32'h1);
        ALUResultM_i = c_A_STORECNT; #1;
        checkCount++; if (ReadDataM_o !== 32'd2) begin errCount++; $display("FAIL cnt_gpio got=%h exp=2", ReadDataM_o); end
    endtask

    task automatic test_async_reset;
        @(negedge clk_i);
        do_store(c_A_GPIO, 32'hFF);
        #1;
        checkCount++; if (gpio_o !== 8'hFF) begin errCount++; $display("FAIL ares_gpio_pre got=%h exp=ff", gpio_o); end
        MemWriteM_i = 1'b1; ALUResultM_i = 32'h0000_0020; WriteDataM_i = 32'h5555_5555;
        #1;
        rst_i = 1'b1;
        #1;
        checkCount++; if (gpio_o !== 8'h00) begin errCount++; $display("FAIL ares_gpio_immediate got=%h exp=00", gpio_o); end
        @(negedge clk_i);
        MemWriteM_i = 1'b0;
        rst_i = 1'b0;
        ALUResultM_i = c_A_MTIME; #1;
        checkCount++; if (ReadDataM_o !== 32'd0) begin errCount++; $display("FAIL ares_mtime0 got=%h exp=0", ReadDataM_o); end
        @(negedge clk_i); #1;
        checkCount++; if (ReadDataM_o !== 32'd1) begin errCount++; $display("FAIL ares_mtime1 got=%h exp=1", ReadDataM_o); end
        ALUResultM_i = 32'h0000_0020; #1;
        checkCount++; if (ReadDataM_o !== 32'h0000_AAAA) begin errCount++; $display("FAIL ares_store_dropped got=%h exp=0000aaaa", ReadDataM_o); end
        ALUResultM_i = 32'h0000_0010; #1;
        checkCount++; if (ReadDataM_o !== 32'hDEAD_BEEF) begin errCount++; $display("FAIL ares_ram_kept got=%h exp=deadbeef", ReadDataM_o); end
        ALUResultM_i = c_A_STORECNT; #1;
        checkCount++; if (ReadDataM_o !== 32'd0) begin errCount++; $display("FAIL ares_storecnt got=%h exp=0", ReadDataM_o); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_timer();
        test_mtime_wrap();
        test_gpio_unmapped();
        test_store_cnt();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", checkCount, errCount);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", checkCount, errCount);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
